// File: rtl/hamming_ser_enc.sv
// Serial Hamming encoder: latches a K-bit word and shifts out
// start bit, data (LSB first), Hamming parity and optional overall parity.
`timescale 1ns/1ps
module hamming_ser_enc #(
  parameter int K   = 4,
  parameter int EXT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out,
  output logic         busy,
  output logic         sof,
  output logic         state_dbg
);

  localparam int R  = (K == 4) ? 3 : (K == 11) ? 4 : 5;
  localparam int N  = 1 + K + R + EXT;
  localparam int CW = $clog2(N);

  generate
    if (!(K == 4 || K == 11 || K == 26)) begin : g_bad_k
      $error("hamming_ser_enc: K must be 4, 11 or 26");
    end
    if (!(EXT == 0 || EXT == 1)) begin : g_bad_ext
      $error("hamming_ser_enc: EXT must be 0 or 1");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Handshake: a word is taken on a rising edge where in_valid && in_ready.
  // in_ready depends only on registered state, never on in_valid.

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [K-1:0]    data_q, data_d;
  logic            out_q, out_d;
  logic            busy_q, busy_d;
  logic            sof_q, sof_d;
  logic [N-1:0]    frame_d;
  logic            last_bit;
  logic            accept;

  // Data bit i sits at the (i+1)-th non-power-of-two codeword position;
  // parity j covers every position with bit j set.
  function automatic logic [R-1:0] calc_par(input logic [K-1:0] d);
    logic [K-1:0] rem;
    logic [R-1:0] par;
    rem = d;
    par = '0;
    for (int p = 3; p <= K + R; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int j = 0; j < R; j++) begin
          if (((p >> j) & 1) == 1 && rem[0]) par = par ^ (R'(1) << j);
        end
        rem = rem >> 1;
      end
    end
    return par;
  endfunction

  function automatic logic [N-1:0] build_frame(input logic [K-1:0] d);
    logic [N-1:0] f;
    logic [R-1:0] par;
    par         = calc_par(d);
    f           = '0;
    f[K:0]      = {d, 1'b1};
    f[K+R:K+1]  = par;
    if (EXT == 1) f[N-1] = ^{d, par};
    return f;
  endfunction

  assign last_bit = (state_q == SEND) && (cnt_q == CW'(N - 1));
  assign in_ready = (state_q == IDLE) || last_bit;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (accept) begin
      state_d = SEND;
      cnt_d   = '0;
      data_d  = in;
    end else if (state_q == SEND) begin
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Outputs are registered: look ahead at the next state's frame bit.
    frame_d = build_frame(data_d);
    out_d   = (state_d == SEND) ? frame_d[cnt_d] : 1'b0;
    busy_d  = (state_d == SEND);
    sof_d   = (state_d == SEND) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      sof_q   <= sof_d;
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign sof       = sof_q;
  assign state_dbg = (state_q == SEND);

endmodule

// File: doc/hamming_ser_enc.md
HAMMING_SER_ENC -- requirements
Module: hamming_ser_enc

Interface
REQ-001 SHALL have parameter K, default 4, meaning data bits per frame; legal values are 4, 11 and 26, and any other value is a compile-time error.
REQ-002 SHALL have parameter EXT, default 0, meaning that 1 appends an overall-parity bit (SECDED) and 0 omits it.
REQ-003 SHALL derive localparams R = 3/4/5 for K = 4/11/26, N = 1+K+R+EXT, and CW = clog2(N).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in, input, K bits: data word, sampled on the accept edge.
REQ-007 SHALL have port in_valid, input, 1 bit: source offers a word.
REQ-008 SHALL have port in_ready, output, 1 bit: encoder can accept a word this cycle.
REQ-009 SHALL have port out, output, 1 bit: registered serial line.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame bit is on out.
REQ-011 SHALL have port sof, output, 1 bit: high during the cycle the start bit is on out.

Function
REQ-012 SHALL have two states: IDLE and SEND, with bit counter cnt[CW-1:0].
REQ-013 SHALL accept a word on a rising edge where in_valid && in_ready, and latch in into an internal register.
REQ-014 SHALL drive in_ready = (state==IDLE) || (state==SEND && cnt==N-1), decoded from registers only.
REQ-015 SHALL, on accept, set state=SEND and cnt=0, so that out=1 (start bit) and sof=1 in the next cycle: one cycle of latency.
REQ-016 SHALL drive out in frame order: cnt=0 start bit 1; cnt=1..K data d0..d(K-1), LSB first; cnt=K+1..K+R parity p0..p(R-1); cnt=N-1 overall parity when EXT=1.
REQ-017 SHALL map data bit di to the (i+1)-th codeword position (1-based, ascending) that is not a power of two, and set pj = XOR of all data bits whose position has bit j set.
REQ-018 SHALL, when EXT=1, make the overall parity bit the XOR of all K data bits and R parity bits, giving even parity over the codeword excluding the start bit.
REQ-019 SHALL compute parity from the latched word only; changes on in during SEND have no effect on the frame.
REQ-020 SHALL, on the edge that ends bit N-1 with in_valid=1, accept the next word and emit its start bit immediately, with no idle gap between frames.
REQ-021 SHALL, on the edge that ends bit N-1 with in_valid=0, return to IDLE with out=0, busy=0, sof=0.
REQ-022 SHALL hold out=0 in IDLE, with busy=1 exactly when state==SEND.
REQ-023 SHALL increment cnt by 1 per cycle in SEND with no wrap beyond N-1.

Reset
REQ-024 SHALL, on rst_n low at any time, including mid-frame, immediately force state=IDLE, cnt=0, out=0, busy=0, sof=0, in_ready=1, and clear the data register to 0.
REQ-025 SHALL discard a partially sent frame on reset; no bit of it appears after rst_n rises.
REQ-026 SHALL make the first accept possible on the first rising edge at which rst_n is high and in_valid is high.

Verification
REQ-027 SHALL be verified with K=4, EXT=0, and in=4'b1011 pulsed valid for one cycle -> out = 1,1,1,0,1,1,0,0 over 8 cycles, then 0; sof high only in the first of those cycles.
REQ-028 SHALL be verified with K=4, EXT=1, same word -> 9-bit frame 1,1,1,0,1,1,0,0,0, and in_ready high only in the 9th cycle.
REQ-029 SHALL be verified with K=4, EXT=0, in_valid held high with words 4'hF then 4'h0 -> frames 1,1,1,1,1,1,1,1 then 1,0,0,0,0,0,0,0 back-to-back, and busy continuously high for 16 cycles.
REQ-030 SHALL be verified with K=11 and all 2^11 words, with a bench model decoding the frames -> zero syndrome for every word; a single flipped bit is corrected to the original word.
REQ-031 SHALL be verified by asserting rst_n low at cnt=3 mid-frame -> out=0 and in_ready=1 asynchronously; the next accepted word produces a complete fresh frame.
REQ-032 SHALL be verified by changing in during SEND -> the emitted frame matches the latched word only.
